// File: rtl/fpu_sig_adder.sv
// fpu_sig_adder: significand add/subtract stage of the FP add/sub datapath.
// Adds or subtracts two aligned unsigned significands. It returns an unsigned
// magnitude, the sign of the result relative to operand a, and the G/R/S bits
// that the normalise/round stage consumes.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       operands valid this cycle
//   operand_a      aligned significand A (larger exponent), WIDTH bits
//   operand_b      aligned significand B (shifted), WIDTH bits
//   effective_sub  1 = A-B, 0 = A+B
//   sticky_in      sticky bit from the alignment shifter
//   out_valid      result valid
//   sum            WIDTH+1 bit magnitude; bit WIDTH is the carry out
//   result_sign    1 when B > A during a subtract
//   guard, round   sum[2], sum[1]
//   sticky         sum[0] | sticky_in
//
// Configuration macro FPU_SIG_ADDER_COMB_EN: when defined, the output register
// is removed. All outputs are then combinational with 0 latency, and clk/rst_n
// are unused. When undefined, the design has 1-cycle registered latency.

module fpu_sig_adder #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             effective_sub,
    input  logic             sticky_in,
    output logic             out_valid,
    output logic [WIDTH:0]   sum,
    output logic             result_sign,
    output logic             guard,
    output logic             round,
    output logic             sticky
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH:0]   add_c;
    logic [WIDTH:0]   a_minus_b_c;
    logic [WIDTH-1:0] b_minus_a_c;
    logic             a_ge_b_c;
    logic [WIDTH:0]   sum_c;
    logic             sign_c;
    logic             guard_c;
    logic             round_c;
    logic             sticky_c;

    // A + ~B + 1: the carry out is set exactly when A >= B (no borrow).
    always_comb begin
        add_c       = {1'b0, operand_a} + {1'b0, operand_b};
        a_minus_b_c = {1'b0, operand_a} + {1'b0, ~operand_b} + SUM_W'(1);
        a_ge_b_c    = a_minus_b_c[WIDTH];
        b_minus_a_c = operand_b - operand_a;
    end

    // Select the magnitude. A == B takes the A >= B path, so zero is never negative.
    always_comb begin
        sum_c  = add_c;
        sign_c = 1'b0;
        if (effective_sub) begin
            if (a_ge_b_c) begin
                sum_c  = {1'b0, a_minus_b_c[WIDTH-1:0]};
                sign_c = 1'b0;
            end else begin
                sum_c  = {1'b0, b_minus_a_c};
                sign_c = 1'b1;
            end
        end
        guard_c  = sum_c[2];
        round_c  = sum_c[1];
        sticky_c = sum_c[0] | sticky_in;
    end

`ifdef FPU_SIG_ADDER_COMB_EN

    // Zero-latency variant: outputs follow the inputs directly.
    always_comb begin
        out_valid   = in_valid;
        sum         = sum_c;
        result_sign = sign_c;
        guard       = guard_c;
        round       = round_c;
        sticky      = sticky_c;
    end

`else

    // Output register: data holds when idle, valid follows in_valid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            sum         <= '0;
            result_sign <= 1'b0;
            guard       <= 1'b0;
            round       <= 1'b0;
            sticky      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum         <= sum_c;
                result_sign <= sign_c;
                guard       <= guard_c;
                round       <= round_c;
                sticky      <= sticky_c;
            end
        end
    end

`endif

endmodule

// File: tb/tb_fpu_sig_adder.sv
// Directed, table-driven bench for fpu_sig_adder in its default registered build.
module tb_fpu_sig_adder;

    localparam int unsigned W = 48;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         sti;
        logic [W:0]   sum;
        logic         sign;
        logic         g;
        logic         r;
        logic         s;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         effective_sub;
    logic         sticky_in;
    logic         out_valid;
    logic [W:0]   sum;
    logic         result_sign;
    logic         guard;
    logic         round;
    logic         sticky;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[12];

    fpu_sig_adder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .effective_sub(effective_sub),
        .sticky_in    (sticky_in),
        .out_valid    (out_valid),
        .sum          (sum),
        .result_sign  (result_sign),
        .guard        (guard),
        .round        (round),
        .sticky       (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input vec_t v, input logic valid);
        in_valid      = valid;
        operand_a     = v.a;
        operand_b     = v.b;
        effective_sub = v.sub;
        sticky_in     = v.sti;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".sum"},   64'(sum), 64'(v.sum));
        check({tag, ".sign"},  64'(result_sign), 64'(v.sign));
        check({tag, ".g"},     64'(guard), 64'(v.g));
        check({tag, ".r"},     64'(round), 64'(v.r));
        check({tag, ".s"},     64'(sticky), 64'(v.s));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(0));
        check({tag, ".sum"},   64'(sum), 64'(0));
        check({tag, ".sign"},  64'(result_sign), 64'(0));
        check({tag, ".g"},     64'(guard), 64'(0));
        check({tag, ".r"},     64'(round), 64'(0));
        check({tag, ".s"},     64'(sticky), 64'(0));
    endtask

    initial begin
        vec_t idle;
        //            a                 b                 sub   sti   sum                       sign  g     r     s
        vecs[0]  = '{48'h64,           48'h32,           1'b0, 1'b0, 49'h96,                   1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 1'b0, 49'h1FFFFFFFFFFFE,        1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{48'h1,            48'h800000000000, 1'b1, 1'b0, 49'h7FFFFFFFFFFF,         1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{48'hABCDEF123456, 48'hABCDEF123456, 1'b1, 1'b0, 49'h0,                    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{48'hFFF,          48'hFFF,          1'b0, 1'b1, 49'h1FFE,                 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{48'h0,            48'h0,            1'b0, 1'b1, 49'h0,                    1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{48'h5,            48'h3,            1'b1, 1'b0, 49'h2,                    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{48'h3,            48'h5,            1'b1, 1'b0, 49'h2,                    1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{48'h0,            48'hFFFFFFFFFFFF, 1'b1, 1'b0, 49'hFFFFFFFFFFFF,         1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{48'hFFFFFFFFFFFF, 48'h0,            1'b1, 1'b1, 49'hFFFFFFFFFFFF,         1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{48'h800000000000, 48'h800000000000, 1'b0, 1'b0, 49'h1000000000000,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{48'h0,            48'h0,            1'b1, 1'b1, 49'h0,                    1'b0, 1'b0, 1'b0, 1'b1};
        idle     = '{48'h123,          48'h456,          1'b1, 1'b1, 49'h0,                    1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(vecs[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one operation per cycle, checked 1 ns after the capturing edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b1);
            @(posedge clk);
            #1;
            check_result($sformatf("v%0d", i), vecs[i]);
        end

        // Idle cycle: valid drops, data holds the last result.
        @(negedge clk);
        drive(idle, 1'b0);
        @(posedge clk);
        #1;
        check("hold.valid", 64'(out_valid), 64'(0));
        check("hold.sum",   64'(sum), 64'(vecs[11].sum));
        check("hold.s",     64'(sticky), 64'(vecs[11].s));

        // Back-to-back: the output changes only on the capturing edge.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(vecs[k], 1'b1);
            #1;
            if (k > 0)
                check($sformatf("b2b%0d.pre", k), 64'(sum), 64'(vecs[k-1].sum));
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d.sum", k), 64'(sum), 64'(vecs[k].sum));
            check($sformatf("b2b%0d.valid", k), 64'(out_valid), 64'(1));
        end

        // Reset mid-stream: load a result with all flags set, then assert reset between edges.
        @(negedge clk);
        drive(vecs[2], 1'b1);
        @(posedge clk);
        #1;
        check_result("prerst", vecs[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        drive(vecs[8], 1'b1);
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[0], 1'b1);
        @(posedge clk);
        #1;
        check_result("postrst", vecs[0]);
        @(negedge clk);
        drive(idle, 1'b0);
        @(posedge clk);
        #1;
        check("postrst_idle.valid", 64'(out_valid), 64'(0));
        check("postrst_idle.sum",   64'(sum), 64'(vecs[0].sum));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
